// File: rtl/pll_reset_seq_if.sv
// Board-side signal bundle of the PLL reset sequencer: lock/soft-reset requests in,
// core reset, CPU clock enable and status out.
interface pll_reset_seq_if;
    logic pll_locked;
    logic soft_rst;
    logic core_rst_n;
    logic cpu_ce;
    logic running;
    logic lock_lost;

    // Sequencer side
    modport master (
        input  pll_locked,
        input  soft_rst,
        output core_rst_n,
        output cpu_ce,
        output running,
        output lock_lost
    );

    // Board/core side
    modport slave (
        output pll_locked,
        output soft_rst,
        input  core_rst_n,
        input  cpu_ce,
        input  running,
        input  lock_lost
    );
endinterface

// File: rtl/pll_reset_seq.sv
// Power-up sequencer: qualifies PLL lock, holds the machine core in reset, then
// releases it and generates a fractional-rate CPU clock enable (CE_NUM/CE_DEN).
module pll_reset_seq #(
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned CE_NUM      = 3,
    parameter int unsigned CE_DEN      = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    pll_reset_seq_if.master bus
);

    localparam int unsigned ACC_RAW_W = $clog2(CE_NUM + CE_DEN);
    localparam int unsigned ACC_W     = (ACC_RAW_W < 16) ? 16 : ACC_RAW_W;
    localparam int unsigned LCNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int unsigned HCNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [ACC_W-1:0]  ACC_INC   = ACC_W'(CE_NUM);
    localparam logic [ACC_W-1:0]  ACC_MOD   = ACC_W'(CE_DEN);

    if (CE_NUM == 0 || CE_NUM >= CE_DEN || LOCK_CYCLES == 0 || HOLD_CYCLES == 0) begin : g_bad_params
        $error("pll_reset_seq: invalid parameter set");
    end

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t              state;
    logic                lk_m;
    logic                lk_s;
    logic [LCNT_W-1:0]   lock_cnt;
    logic [HCNT_W-1:0]   hold_cnt;
    logic [ACC_W-1:0]    acc;
    logic                core_rst_n_q;
    logic                cpu_ce_q;
    logic                running_q;
    logic                lock_lost_q;

    logic [ACC_W-1:0]    acc_sum_c;
    logic                ce_hit_c;

    // Accumulator never exceeds CE_NUM+CE_DEN-1, so the sum cannot overflow ACC_W
    assign acc_sum_c = acc + ACC_INC;
    assign ce_hit_c  = (acc_sum_c >= ACC_MOD);

    // Sequencer FSM with registered outputs; reset/enable default low and are
    // re-asserted only while the FSM stays in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_LOCK;
            lk_m         <= 1'b0;
            lk_s         <= 1'b0;
            lock_cnt     <= '0;
            hold_cnt     <= '0;
            acc          <= '0;
            core_rst_n_q <= 1'b0;
            cpu_ce_q     <= 1'b0;
            running_q    <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            lk_m         <= bus.pll_locked;
            lk_s         <= lk_m;
            core_rst_n_q <= 1'b0;
            cpu_ce_q     <= 1'b0;
            running_q    <= 1'b0;
            acc          <= '0;

            case (state)
                WAIT_LOCK: begin
                    lock_cnt <= '0;
                    if (lk_s) begin
                        state <= QUALIFY;
                    end
                end

                QUALIFY: begin
                    if (!lk_s) begin
                        state    <= WAIT_LOCK;
                        lock_cnt <= '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state    <= HOLD;
                        lock_cnt <= '0;
                        hold_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + LCNT_W'(1);
                    end
                end

                HOLD: begin
                    if (!lk_s) begin
                        state       <= WAIT_LOCK;
                        hold_cnt    <= '0;
                        lock_lost_q <= 1'b1;
                    end else if (bus.soft_rst) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= RUN;
                        hold_cnt  <= '0;
                        running_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HCNT_W'(1);
                    end
                end

                RUN: begin
                    // Lock loss outranks a soft reset request
                    if (!lk_s) begin
                        state       <= WAIT_LOCK;
                        lock_lost_q <= 1'b1;
                    end else if (bus.soft_rst) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end else begin
                        running_q    <= 1'b1;
                        core_rst_n_q <= 1'b1;
                        if (ce_hit_c) begin
                            acc      <= acc_sum_c - ACC_MOD;
                            cpu_ce_q <= 1'b1;
                        end else begin
                            acc <= acc_sum_c;
                        end
                    end
                end

                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign bus.core_rst_n = core_rst_n_q;
    assign bus.cpu_ce     = cpu_ce_q;
    assign bus.running    = running_q;
    assign bus.lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq: a short-count instance for sequencing scenarios
// and a default-parameter instance for clock-enable rate checks.
module tb_pll_reset_seq;

    logic clk;
    logic rst_na;
    logic rst_nb;

    int vectors;
    int miscompares;

    int first_run;
    int first_core;
    int first_ce;
    int low_cnt;
    int pulses;
    int last_ce;
    int min_gap;
    int max_gap;
    int gap;
    int ce_bad;
    int seen_run;
    int seen_core;
    int seen_lost;

    pll_reset_seq_if ifa ();
    pll_reset_seq_if ifb ();

    pll_reset_seq #(
        .LOCK_CYCLES(8),
        .HOLD_CYCLES(4),
        .CE_NUM     (3),
        .CE_DEN     (200)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_na),
        .bus  (ifa)
    );

    pll_reset_seq dut_b (
        .clk  (clk),
        .rst_n(rst_nb),
        .bus  (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_na = 1'b0;
        rst_nb = 1'b0;
        ifa.pll_locked = 1'b0;
        ifa.soft_rst   = 1'b0;
        ifb.pll_locked = 1'b0;
        ifb.soft_rst   = 1'b0;

        // Reset state
        tick(3);
        chk("rst_core_rst_n", 32'(ifa.core_rst_n), 0);
        chk("rst_cpu_ce",     32'(ifa.cpu_ce),     0);
        chk("rst_running",    32'(ifa.running),    0);
        chk("rst_lock_lost",  32'(ifa.lock_lost),  0);

        // Locked from reset release: RUN at edge 3+8+4, core reset released one edge later
        ifa.pll_locked = 1'b1;
        rst_na = 1'b1;
        first_run = 0; first_core = 0; first_ce = 0; ce_bad = 0;
        for (int n = 1; n <= 100; n++) begin
            tick(1);
            if (ifa.running && first_run == 0) first_run = n;
            if (ifa.core_rst_n && first_core == 0) first_core = n;
            if (ifa.cpu_ce && first_ce == 0) first_ce = n;
            if (ifa.cpu_ce && !ifa.core_rst_n) ce_bad = 1;
        end
        chk("pwrup_running_edge", first_run, 15);
        chk("pwrup_core_edge",    first_core, 16);
        chk("pwrup_first_ce",     first_ce, 82);
        chk("pwrup_ce_in_reset",  ce_bad, 0);
        chk("pwrup_lock_lost",    32'(ifa.lock_lost), 0);

        // Lock drop in RUN: two synchronizer edges, then exit on the third
        ifa.pll_locked = 1'b0;
        tick(2);
        chk("drop_sync_latency", 32'(ifa.running), 1);
        tick(1);
        chk("drop_core_rst_n", 32'(ifa.core_rst_n), 0);
        chk("drop_cpu_ce",     32'(ifa.cpu_ce),     0);
        chk("drop_running",    32'(ifa.running),    0);
        chk("drop_lock_lost",  32'(ifa.lock_lost),  1);

        // Relock requires the full qualification again; lock_lost stays set
        ifa.pll_locked = 1'b1;
        first_run = 0;
        for (int n = 1; n <= 40; n++) begin
            tick(1);
            if (ifa.running && first_run == 0) first_run = n;
        end
        chk("relock_running_edge", first_run, 15);
        chk("relock_lock_lost",    32'(ifa.lock_lost), 1);

        // Soft reset held for 10 edges: core reset low for 10+4 edges, accumulator restarts
        ifa.soft_rst = 1'b1;
        low_cnt = 0; first_run = 0; first_ce = 0;
        for (int n = 1; n <= 100; n++) begin
            tick(1);
            if (n == 10) ifa.soft_rst = 1'b0;
            if (!ifa.core_rst_n) low_cnt++;
            if (ifa.running && first_run == 0) first_run = n;
            if (ifa.cpu_ce && first_ce == 0) first_ce = n;
        end
        chk("soft_core_low_cycles", low_cnt, 14);
        chk("soft_running_edge",    first_run, 14);
        chk("soft_first_ce",        first_ce, 81);

        // Asynchronous reset between edges clears everything, including lock_lost
        #3;
        rst_na = 1'b0;
        #1;
        chk("async_core_rst_n", 32'(ifa.core_rst_n), 0);
        chk("async_cpu_ce",     32'(ifa.cpu_ce),     0);
        chk("async_running",    32'(ifa.running),    0);
        chk("async_lock_lost",  32'(ifa.lock_lost),  0);
        tick(1);
        rst_na = 1'b1;
        first_run = 0; first_core = 0;
        for (int n = 1; n <= 30; n++) begin
            tick(1);
            if (ifa.running && first_run == 0) first_run = n;
            if (ifa.core_rst_n && first_core == 0) first_core = n;
        end
        chk("recover_running_edge", first_run, 15);
        chk("recover_core_edge",    first_core, 16);

        // Short lock pulse aborts qualification without raising lock_lost
        rst_na = 1'b0;
        ifa.pll_locked = 1'b0;
        tick(2);
        rst_na = 1'b1;
        tick(3);
        ifa.pll_locked = 1'b1;
        seen_run = 0; seen_core = 0; seen_lost = 0;
        for (int n = 1; n <= 35; n++) begin
            tick(1);
            if (n == 5) ifa.pll_locked = 1'b0;
            if (ifa.running) seen_run = 1;
            if (ifa.core_rst_n) seen_core = 1;
            if (ifa.lock_lost) seen_lost = 1;
        end
        chk("glitch_running",   seen_run, 0);
        chk("glitch_core",      seen_core, 0);
        chk("glitch_lock_lost", seen_lost, 0);

        // Counter was cleared: a fresh lock needs the full count again
        ifa.pll_locked = 1'b1;
        first_run = 0;
        for (int n = 1; n <= 30; n++) begin
            tick(1);
            if (ifa.running && first_run == 0) first_run = n;
        end
        chk("glitch_requal_edge", first_run, 15);

        // Default parameters: qualification timing and 2000 RUN cycles of cpu_ce
        ifb.pll_locked = 1'b1;
        rst_nb = 1'b1;
        first_run = 0;
        for (int n = 1; n <= 1200 && first_run == 0; n++) begin
            tick(1);
            if (ifb.running) first_run = n;
        end
        chk("dflt_running_edge", first_run, 1043);

        pulses = 0; first_ce = 0; last_ce = 0; min_gap = 1000000; max_gap = 0; ce_bad = 0;
        for (int k = 1; k <= 2000; k++) begin
            tick(1);
            if (ifb.cpu_ce) begin
                pulses++;
                if (first_ce == 0) begin
                    first_ce = k;
                end else begin
                    gap = k - last_ce;
                    if (gap < min_gap) min_gap = gap;
                    if (gap > max_gap) max_gap = gap;
                end
                last_ce = k;
            end
            if (ifb.cpu_ce && !ifb.core_rst_n) ce_bad = 1;
        end
        chk("dflt_ce_pulses",    pulses, 30);
        chk("dflt_first_ce",     first_ce, 67);
        chk("dflt_min_gap",      min_gap, 66);
        chk("dflt_max_gap",      max_gap, 67);
        chk("dflt_ce_in_reset",  ce_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter LOCK_CYCLES, default 1024: consecutive synchronized-locked cycles required before leaving lock qualification.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles the core reset stays asserted after lock qualification or a soft reset.
REQ-003 Parameter CE_NUM, default 3: phase-accumulator increment per clock.
REQ-004 Parameter CE_DEN, default 200: phase-accumulator modulus (3/200 of 50 MHz gives 750 kHz).
REQ-005 clk  input  1  system clock; single clock domain; driven by the PLL's 50 MHz outclk_0.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 pll_locked  input  1  PLL locked flag; asynchronous to clk.
REQ-008 soft_rst  input  1  synchronous user reset request (OSD/button), level-sensitive.
REQ-009 core_rst_n  output  1  active-low reset to the machine core; registered.
REQ-010 cpu_ce  output  1  single-cycle clock enable for the CPU; registered.
REQ-011 running  output  1  high only in state RUN.
REQ-012 lock_lost  output  1  sticky flag: lock dropped while in HOLD or RUN.

Function
REQ-013 The block SHALL pass pll_locked through a 2-FF synchronizer (lk_s); every reference to "locked" below means lk_s.
REQ-014 The FSM SHALL have four states: WAIT_LOCK, QUALIFY, HOLD, RUN.
REQ-015 WAIT_LOCK: the lock counter is cleared; on locked=1 -> QUALIFY.
REQ-016 QUALIFY: the counter increments each cycle with locked=1; locked=0 -> WAIT_LOCK with the counter cleared; counter reaching LOCK_CYCLES-1 while locked=1 -> HOLD.
REQ-017 HOLD: the hold counter runs from 0; after exactly HOLD_CYCLES cycles in HOLD -> RUN, provided locked=1 and soft_rst=0.
REQ-018 RUN: soft_rst=1 -> HOLD with the hold counter restarted.
REQ-019 While soft_rst stays high in HOLD, the hold counter SHALL stay at 0.
REQ-020 In HOLD or RUN, locked=0 -> WAIT_LOCK and sets lock_lost; lock loss SHALL take priority over soft_rst.
REQ-021 core_rst_n SHALL be 1 exactly in the cycle after the FSM is in RUN, i.e. one register stage; it SHALL be 0 in all other states.
REQ-022 The phase accumulator acc SHALL be wide enough for CE_NUM+CE_DEN-1, minimum 16 bits.
REQ-023 In RUN, each cycle: if acc+CE_NUM >= CE_DEN then acc <= acc+CE_NUM-CE_DEN and cpu_ce <= 1; otherwise acc <= acc+CE_NUM and cpu_ce <= 0.
REQ-024 Outside RUN, acc SHALL be held at 0 and cpu_ce at 0.
REQ-025 cpu_ce SHALL never be high in a cycle where core_rst_n is 0.
REQ-026 Over any CE_DEN consecutive RUN cycles, cpu_ce SHALL pulse exactly CE_NUM times.
REQ-027 The first cpu_ce after entering RUN SHALL occur on RUN cycle ceil(CE_DEN/CE_NUM) (67 with defaults).
REQ-028 lock_lost SHALL clear only on rst_n assertion.
REQ-029 Parameter constraints: CE_NUM < CE_DEN, CE_NUM >= 1, LOCK_CYCLES >= 1, HOLD_CYCLES >= 1.

Reset
REQ-030 Asserting rst_n=0 at any time, including mid-RUN, SHALL immediately set the following:
- state = WAIT_LOCK;
- all counters and acc = 0;
- synchronizer flops = 0;
- core_rst_n = 0, cpu_ce = 0, running = 0, lock_lost = 0.
REQ-031 After rst_n deasserts, the first possible state change SHALL occur after synchronizer latency, i.e. no earlier than the 2nd clock edge.

Verification
REQ-032 Scenario: LOCK_CYCLES=8, HOLD_CYCLES=4, pll_locked=1 from reset release -> running rises on edge 2+8+4 (±1 documented), core_rst_n one cycle later.
REQ-033 Scenario: pll_locked pulses high for 5 cycles then low in QUALIFY (LOCK_CYCLES=8) -> returns to WAIT_LOCK, core_rst_n stays 0, lock_lost stays 0.
REQ-034 Scenario: in RUN, pll_locked drops -> within 3 cycles core_rst_n=0, cpu_ce=0, lock_lost=1; relock -> full requalify, lock_lost remains 1.
REQ-035 Scenario: in RUN, soft_rst held 10 cycles -> core_rst_n low for 10+HOLD_CYCLES cycles (±1), acc restarts at 0.
REQ-036 Scenario: defaults, 2000 RUN cycles -> exactly 30 cpu_ce pulses, first at RUN cycle 67, pulse spacing 66 or 67 only.
REQ-037 Scenario: rst_n asserted mid-RUN asynchronously, between edges -> all outputs 0 before next edge; recovery sequence identical to REQ-032.
